// File: rtl/trigger_edge_acq.sv
// rtl/trigger_edge_acq.sv - edge/level acquisition trigger with hysteresis, confirmation and holdoff
// Qualifies a sample stream against a level and reports the address of the first qualifying sample.
module trigger_edge_acq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int SIGNED     = 0,
  parameter int CONFIRM_W  = 8,
  parameter int HOLDOFF_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_level,
  input  logic [DATA_WIDTH-1:0] cfg_hyst,
  input  logic [CONFIRM_W-1:0]  cfg_confirm,
  input  logic [HOLDOFF_W-1:0]  cfg_holdoff,
  input  logic                  cfg_auto_rearm,
  input  logic                  cfg_rearm,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  trig_pulse,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [15:0]           trig_count,
  output logic                  armed,
  output logic [2:0]            state
);

  // Two guard bits keep level +/- hyst exact before clamping to the sample range.
  localparam int EW = DATA_WIDTH + 2;
  localparam logic signed [EW-1:0] MIN_X = (SIGNED != 0) ?
      {3'b111, {(DATA_WIDTH-1){1'b0}}} : {EW{1'b0}};
  localparam logic signed [EW-1:0] MAX_X = (SIGNED != 0) ?
      {3'b000, {(DATA_WIDTH-1){1'b1}}} : {2'b00, {DATA_WIDTH{1'b1}}};
  localparam logic [CONFIRM_W:0]   Q_ONE = {{CONFIRM_W{1'b0}}, 1'b1};
  localparam logic [HOLDOFF_W-1:0] H_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    QUAL = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q;
  logic                  pre_r_q;
  logic                  pre_f_q;
  logic                  dir_q;
  logic [CONFIRM_W-1:0]  qcnt_q;
  logic [HOLDOFF_W-1:0]  hcnt_q;
  logic [ADDR_WIDTH-1:0] cand_addr_q;
  logic [ADDR_WIDTH-1:0] trig_addr_q;
  logic [15:0]           trig_count_q;
  logic                  trig_pulse_q;

  logic signed [EW-1:0] data_x;
  logic signed [EW-1:0] level_x;
  logic signed [EW-1:0] hyst_x;
  logic signed [EW-1:0] lo_raw;
  logic signed [EW-1:0] hi_raw;
  logic signed [EW-1:0] th_lo;
  logic signed [EW-1:0] th_hi;

  assign data_x  = (SIGNED != 0) ? {{2{in_data[DATA_WIDTH-1]}}, in_data}
                                 : {2'b00, in_data};
  assign level_x = (SIGNED != 0) ? {{2{cfg_level[DATA_WIDTH-1]}}, cfg_level}
                                 : {2'b00, cfg_level};
  assign hyst_x  = {2'b00, cfg_hyst};
  assign lo_raw  = level_x - hyst_x;
  assign hi_raw  = level_x + hyst_x;
  assign th_lo   = (lo_raw < MIN_X) ? MIN_X : lo_raw;
  assign th_hi   = (hi_raw > MAX_X) ? MAX_X : hi_raw;

  logic hi_cand;
  logic lo_cand;
  logic below;
  logic above;
  logic rise_en;
  logic fall_en;
  logic lvl_en;
  logic cand_r;
  logic cand_f;
  logic arm_cand;
  logic qual_ok;
  logic [CONFIRM_W:0] tgt;
  logic [CONFIRM_W:0] qnext;
  logic fire;
  logic [ADDR_WIDTH-1:0] fire_addr;

  assign hi_cand = data_x >= level_x;
  assign lo_cand = data_x <= level_x;
  assign below   = data_x < th_lo;
  assign above   = data_x > th_hi;

  assign rise_en = (cfg_mode == 2'b00) || (cfg_mode == 2'b10);
  assign fall_en = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);
  assign lvl_en  = (cfg_mode == 2'b11);

  // Candidates use the registered flags so a precondition always comes from an earlier sample.
  assign cand_r   = hi_cand && (lvl_en || (rise_en && pre_r_q));
  assign cand_f   = lo_cand && fall_en && pre_f_q;
  assign arm_cand = cand_r || cand_f;
  assign qual_ok  = dir_q ? cand_f : cand_r;

  assign tgt   = (cfg_confirm == '0) ? Q_ONE : {1'b0, cfg_confirm};
  assign qnext = {1'b0, qcnt_q} + Q_ONE;

  assign fire = in_valid &&
                (((state_q == ARM) && arm_cand && (tgt == Q_ONE)) ||
                 ((state_q == QUAL) && qual_ok && (qnext >= tgt)));
  assign fire_addr = (state_q == ARM) ? in_addr : cand_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_r_q      <= 1'b0;
      pre_f_q      <= 1'b0;
      dir_q        <= 1'b0;
      qcnt_q       <= '0;
      hcnt_q       <= '0;
      cand_addr_q  <= '0;
      trig_addr_q  <= '0;
      trig_count_q <= '0;
      trig_pulse_q <= 1'b0;
    end else begin
      trig_pulse_q <= 1'b0;
      if (!cfg_enable) begin
        state_q <= IDLE;
        pre_r_q <= 1'b0;
        pre_f_q <= 1'b0;
        qcnt_q  <= '0;
        hcnt_q  <= '0;
      end else if (fire) begin
        trig_pulse_q <= 1'b1;
        trig_addr_q  <= fire_addr;
        if (trig_count_q != 16'hFFFF) begin
          trig_count_q <= trig_count_q + 16'd1;
        end
        pre_r_q <= 1'b0;
        pre_f_q <= 1'b0;
        qcnt_q  <= '0;
        if (cfg_holdoff == '0) begin
          state_q <= cfg_auto_rearm ? ARM : DONE;
        end else begin
          state_q <= HOLD;
          hcnt_q  <= cfg_holdoff;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARM;
            pre_r_q <= 1'b0;
            pre_f_q <= 1'b0;
          end
          ARM: begin
            if (in_valid) begin
              pre_r_q <= pre_r_q | below;
              pre_f_q <= pre_f_q | above;
              if (arm_cand) begin
                state_q     <= QUAL;
                cand_addr_q <= in_addr;
                dir_q       <= ~cand_r;
                qcnt_q      <= Q_ONE[CONFIRM_W-1:0];
              end
            end
          end
          QUAL: begin
            if (in_valid) begin
              if (qual_ok) begin
                qcnt_q <= qnext[CONFIRM_W-1:0];
              end else begin
                // A failing sample restarts the search and may itself be a new precondition.
                state_q <= ARM;
                qcnt_q  <= '0;
                pre_r_q <= below;
                pre_f_q <= above;
              end
            end
          end
          HOLD: begin
            if (hcnt_q == H_ONE) begin
              state_q <= cfg_auto_rearm ? ARM : DONE;
              hcnt_q  <= '0;
            end else begin
              hcnt_q <= hcnt_q - H_ONE;
            end
          end
          DONE: begin
            if (cfg_rearm) begin
              state_q <= ARM;
              pre_r_q <= 1'b0;
              pre_f_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign trig_pulse = trig_pulse_q;
  assign trig_addr  = trig_addr_q;
  assign trig_count = trig_count_q;
  assign armed      = (state_q == ARM) || (state_q == QUAL);
  assign state      = state_q;

endmodule

// File: tb/tb_trigger_edge_acq.sv
// tb/tb_trigger_edge_acq.sv - directed self-checking bench for trigger_edge_acq
// An unsigned and a signed instance share stimulus; each check targets the relevant one.
module tb_trigger_edge_acq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_level;
  logic [15:0] cfg_hyst;
  logic [7:0]  cfg_confirm;
  logic [15:0] cfg_holdoff;
  logic        cfg_auto_rearm;
  logic        cfg_rearm;
  logic        in_valid;
  logic [15:0] in_data;
  logic [31:0] in_addr;

  logic        u_pulse, s_pulse;
  logic [31:0] u_addr, s_addr;
  logic [15:0] u_count, s_count;
  logic        u_armed, s_armed;
  logic [2:0]  u_state, s_state;

  int n_checks = 0;
  int n_pass   = 0;
  int u_pulses = 0;

  always #5 clk = ~clk;

  trigger_edge_acq #(.SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_hyst(cfg_hyst), .cfg_confirm(cfg_confirm),
    .cfg_holdoff(cfg_holdoff), .cfg_auto_rearm(cfg_auto_rearm), .cfg_rearm(cfg_rearm),
    .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .trig_pulse(u_pulse), .trig_addr(u_addr), .trig_count(u_count),
    .armed(u_armed), .state(u_state)
  );

  trigger_edge_acq #(.SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_hyst(cfg_hyst), .cfg_confirm(cfg_confirm),
    .cfg_holdoff(cfg_holdoff), .cfg_auto_rearm(cfg_auto_rearm), .cfg_rearm(cfg_rearm),
    .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .trig_pulse(s_pulse), .trig_addr(s_addr), .trig_count(s_count),
    .armed(s_armed), .state(s_state)
  );

  always @(negedge clk) if (u_pulse === 1'b1) u_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs seen right after a drive reflect the posedge that accepted the previous drive.
  task automatic drive(input logic v, input logic [15:0] d, input logic [31:0] a);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_addr  = a;
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_mode = 2'b00; cfg_level = 16'd1000;
    cfg_hyst = 16'd50; cfg_confirm = 8'd3; cfg_holdoff = 16'd0; cfg_auto_rearm = 1'b1;
    cfg_rearm = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
    repeat (3) drive(0, 0, 0);
    check("rst_state", u_state, 0);
    check("rst_pulse", u_pulse, 0);
    check("rst_addr", u_addr, 0);
    check("rst_count", u_count, 0);
    check("rst_armed", u_armed, 0);

    rst = 1'b0; cfg_enable = 1'b1;
    drive(0, 0, 0);
    check("idle_to_arm", u_state, 1);
    check("armed_high", u_armed, 1);

    // Rising, confirm 3
    drive(1, 16'd900, 32'h100);
    drive(1, 16'd1010, 32'hA0);
    drive(1, 16'd1020, 32'hA1);
    drive(1, 16'd1030, 32'hA2);
    check("t1_no_early_pulse", u_pulse, 0);
    drive(0, 0, 0);
    check("t1_pulse", u_pulse, 1);
    check("t1_addr", u_addr, 32'hA0);
    check("t1_count", u_count, 1);
    check("t1_rearmed", u_state, 1);
    drive(0, 0, 0);
    check("t1_pulse_one_cycle", u_pulse, 0);

    // Dip aborts qualification; 990 is not below th_lo so no new precondition
    drive(1, 16'd900, 32'hB0);
    drive(1, 16'd1010, 32'hB1);
    drive(1, 16'd990, 32'hB2);
    drive(1, 16'd1010, 32'hA3);
    drive(1, 16'd1020, 32'hB4);
    drive(1, 16'd1030, 32'hB5);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("t2_no_trig_count", u_count, 1);
    check("t2_state_arm", u_state, 1);
    drive(1, 16'd940, 32'hB6);
    drive(1, 16'd1010, 32'hB3);
    drive(1, 16'd1020, 32'hB7);
    drive(1, 16'd1030, 32'hB8);
    drive(0, 0, 0);
    check("t2_count", u_count, 2);
    check("t2_addr", u_addr, 32'hB3);

    // Chatter inside the hysteresis band
    drive(1, 16'd960, 32'h10);
    drive(1, 16'd1040, 32'h11);
    drive(1, 16'd970, 32'h12);
    drive(1, 16'd1030, 32'h13);
    drive(1, 16'd1000, 32'h14);
    drive(1, 16'd1045, 32'h15);
    drive(0, 0, 0);
    check("t3_count", u_count, 2);
    check("t3_armed", u_armed, 1);
    check("t3_s_count", s_count, 2);

    // Falling, level -100, confirm 1
    cfg_mode = 2'b01; cfg_level = 16'hFF9C; cfg_hyst = 16'd10; cfg_confirm = 8'd1;
    drive(1, 16'hFFCE, 32'hB0);
    drive(1, 16'hFF88, 32'hB1);
    drive(0, 0, 0);
    check("t4_s_pulse", s_pulse, 1);
    check("t4_s_addr", s_addr, 32'hB1);
    check("t4_s_count", s_count, 3);
    check("t4_u_count", u_count, 3);
    // +16 is above th_hi only when read as signed
    drive(1, 16'h0010, 32'hC0);
    drive(1, 16'hFF88, 32'hC1);
    drive(0, 0, 0);
    check("t4b_s_addr", s_addr, 32'hC1);
    check("t4b_s_count", s_count, 4);
    check("t4b_u_count", u_count, 3);
    check("t4b_u_addr", u_addr, 32'hB1);

    // Single shot, holdoff 20
    cfg_mode = 2'b00; cfg_level = 16'd1000; cfg_hyst = 16'd50; cfg_confirm = 8'd1;
    cfg_auto_rearm = 1'b0; cfg_holdoff = 16'd20;
    drive(1, 16'd900, 32'hD1);
    drive(1, 16'd1010, 32'hD0);
    drive(0, 0, 0);
    check("t5_pulse", u_pulse, 1);
    check("t5_addr", u_addr, 32'hD0);
    check("t5_hold_first", u_state, 3);
    for (int i = 1; i < 20; i++) drive(0, 0, 0);
    check("t5_hold_last", u_state, 3);
    drive(0, 0, 0);
    check("t5_done", u_state, 4);
    drive(1, 16'd900, 32'hD2);
    drive(1, 16'd1010, 32'hD5);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("t5_done_ignores", u_count, 4);
    check("t5_still_done", u_state, 4);
    cfg_rearm = 1'b1;
    drive(0, 0, 0);
    cfg_rearm = 1'b0;
    check("t5_rearm", u_state, 1);

    // Enable dropped mid-QUAL
    cfg_confirm = 8'd3; cfg_holdoff = 16'd0; cfg_auto_rearm = 1'b1;
    drive(1, 16'd900, 32'hE0);
    drive(1, 16'd1010, 32'hE1);
    drive(1, 16'd1020, 32'hE2);
    cfg_enable = 1'b0;
    check("t6_in_qual", u_state, 2);
    drive(0, 0, 0);
    check("t6_idle", u_state, 0);
    check("t6_armed_low", u_armed, 0);
    check("t6_no_pulse", u_pulse, 0);
    check("t6_count_kept", u_count, 4);
    check("t6_addr_kept", u_addr, 32'hD0);

    // Reset during HOLD
    cfg_enable = 1'b1; cfg_confirm = 8'd1; cfg_holdoff = 16'd20;
    drive(0, 0, 0);
    drive(1, 16'd900, 32'hF0);
    drive(1, 16'd1010, 32'hF1);
    drive(0, 0, 0);
    check("t7_count", u_count, 5);
    repeat (3) drive(0, 0, 0);
    check("t7_in_hold", u_state, 3);
    rst = 1'b1;
    drive(0, 0, 0);
    check("t7_rst_state", u_state, 0);
    check("t7_rst_count", u_count, 0);
    check("t7_rst_addr", u_addr, 0);
    check("t7_rst_armed", u_armed, 0);
    check("t7_rst_pulse", u_pulse, 0);
    rst = 1'b0;
    drive(0, 0, 0);
    check("total_pulses", u_pulses, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
